// File: rtl/exe_alu_stage.sv
// EXE stage: ARM data-processing ALU, NZCV status register, EXE/MEM pipeline register
// and the combinational branch target for IF.
module exe_alu_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [3:0]        exe_cmd,
  input  logic              s_in,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [23:0]       imm24,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [REG_W-1:0]  dest_in,
  input  logic [DATA_W-1:0] st_val_in,
  output logic [DATA_W-1:0] alu_res_q,
  output logic [DATA_W-1:0] st_val_q,
  output logic [REG_W-1:0]  dest_q,
  output logic              wb_en_q,
  output logic              mem_r_en_q,
  output logic              mem_w_en_q,
  output logic              valid_q,
  output logic [3:0]        status_q,
  output logic [DATA_W-1:0] branch_addr
);

  localparam int unsigned SUM_W = DATA_W + 1;
  localparam int unsigned MSB   = DATA_W - 1;
  localparam int unsigned EXT_W = DATA_W - 24;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [DATA_W-1:0] res;
  logic [SUM_W-1:0]  sum;
  logic              c_cur;
  logic              v_cur;
  logic              c_next;
  logic              v_next;
  logic [3:0]        status_next;
  logic              status_upd;
  logic              carry_q;

  assign c_cur   = status_q[1];
  assign v_cur   = status_q[0];
  assign carry_q = status_q[1];

  // ALU: subtraction is a + ~b + carry-in, so C=1 means no borrow
  always_comb begin
    res    = '0;
    sum    = '0;
    c_next = c_cur;
    v_next = v_cur;
    unique case (exe_cmd)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum    = {1'b0, val1} + {1'b0, val2}
               + ((exe_cmd == CMD_ADC) ? SUM_W'(carry_q) : SUM_W'(0));
        res    = sum[MSB:0];
        c_next = sum[DATA_W];
        v_next = (val1[MSB] == val2[MSB]) && (res[MSB] != val1[MSB]);
      end
      CMD_SUB, CMD_SBC: begin
        sum    = {1'b0, val1} + {1'b0, ~val2}
               + ((exe_cmd == CMD_SBC) ? SUM_W'(carry_q) : SUM_W'(1));
        res    = sum[MSB:0];
        c_next = sum[DATA_W];
        v_next = (val1[MSB] != val2[MSB]) && (res[MSB] != val1[MSB]);
      end
      CMD_AND: res = val1 & val2;
      CMD_ORR: res = val1 | val2;
      CMD_EOR: res = val1 ^ val2;
      default: res = '0;
    endcase
    status_next = {res[MSB], (res == '0), c_next, v_next};
  end

  assign status_upd = valid_in & s_in & ~freeze & ~flush;

  // Status register: only flag-setting real instructions that actually advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 4'b0000;
    end else if (status_upd) begin
      status_q <= status_next;
    end
  end

  // EXE/MEM register: freeze holds everything, flush bubbles control only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_res_q  <= '0;
      st_val_q   <= '0;
      dest_q     <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (freeze) begin
      alu_res_q  <= alu_res_q;
    end else if (flush) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      alu_res_q  <= res;
      st_val_q   <= st_val_in;
      dest_q     <= dest_in;
      wb_en_q    <= wb_en_in & valid_in;
      mem_r_en_q <= mem_r_en_in & valid_in;
      mem_w_en_q <= mem_w_en_in & valid_in;
      valid_q    <= valid_in;
    end
  end

  assign branch_addr = pc_in + ({{EXT_W{imm24[23]}}, imm24} << 2);

endmodule

// File: tb/tb_exe_alu_stage.sv
// Directed bench for exe_alu_stage: ALU ops, NZCV behaviour, freeze/flush/bubble,
// async reset and branch target.
module tb_exe_alu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze, flush, valid_in, s_in;
  logic [3:0]  exe_cmd;
  logic [31:0] val1, val2, pc_in, st_val_in;
  logic [23:0] imm24;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_res_q, st_val_q, branch_addr;
  logic [3:0]  dest_q, status_q;
  logic        wb_en_q, mem_r_en_q, mem_w_en_q, valid_q;

  int total = 0;
  int bad   = 0;

  exe_alu_stage dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .exe_cmd(exe_cmd), .s_in(s_in), .val1(val1), .val2(val2), .pc_in(pc_in),
    .imm24(imm24), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .dest_in(dest_in), .st_val_in(st_val_in),
    .alu_res_q(alu_res_q), .st_val_q(st_val_q), .dest_q(dest_q), .wb_en_q(wb_en_q),
    .mem_r_en_q(mem_r_en_q), .mem_w_en_q(mem_w_en_q), .valid_q(valid_q),
    .status_q(status_q), .branch_addr(branch_addr)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one real instruction with wb_en set
  task automatic issue(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                       input logic [31:0] b);
    valid_in = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    exe_cmd = cmd; s_in = s; val1 = a; val2 = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; freeze = 0; flush = 0; valid_in = 0; s_in = 0; exe_cmd = 4'b0;
    val1 = '0; val2 = '0; pc_in = '0; imm24 = '0; st_val_in = '0;
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; dest_in = '0;
    tick(); tick();
    total++;
    if ({alu_res_q, st_val_q, dest_q, wb_en_q, mem_r_en_q, mem_w_en_q, valid_q, status_q} !== '0) begin
      bad++; $display("FAIL reset_state res=%h status=%b valid=%b want all zero", alu_res_q, status_q, valid_q);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add_overflow();
    issue(4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h1);
    dest_in = 4'd3; st_val_in = 32'hCAFE_0001;
    tick();
    total++;
    if (alu_res_q !== 32'h8000_0000 || status_q !== 4'b1001) begin
      bad++; $display("FAIL add_ovf res=%h status=%b want 80000000 1001", alu_res_q, status_q);
    end
    total++;
    if (valid_q !== 1'b1 || wb_en_q !== 1'b1 || dest_q !== 4'd3 || st_val_q !== 32'hCAFE_0001) begin
      bad++; $display("FAIL add_ctrl valid=%b wb=%b dest=%0d st=%h want 1 1 3 cafe0001", valid_q, wb_en_q, dest_q, st_val_q);
    end
  endtask

  task automatic test_sub_sbc();
    issue(4'b0100, 1'b1, 32'd5, 32'd5);
    tick();
    total++;
    if (alu_res_q !== 32'd0 || status_q !== 4'b0110) begin
      bad++; $display("FAIL sub_eq res=%h status=%b want 0 0110", alu_res_q, status_q);
    end
    issue(4'b0101, 1'b1, 32'd5, 32'd3);
    tick();
    total++;
    if (alu_res_q !== 32'd2 || status_q !== 4'b0010) begin
      bad++; $display("FAIL sbc_c1 res=%h status=%b want 2 0010", alu_res_q, status_q);
    end
    issue(4'b0100, 1'b1, 32'd1, 32'd2);
    tick();
    total++;
    if (alu_res_q !== 32'hFFFF_FFFF || status_q !== 4'b1000) begin
      bad++; $display("FAIL sub_borrow res=%h status=%b want ffffffff 1000", alu_res_q, status_q);
    end
    issue(4'b0101, 1'b1, 32'd5, 32'd3);
    tick();
    total++;
    if (alu_res_q !== 32'd1 || status_q !== 4'b0010) begin
      bad++; $display("FAIL sbc_c0 res=%h status=%b want 1 0010", alu_res_q, status_q);
    end
    issue(4'b0100, 1'b1, 32'h8000_0000, 32'd1);
    tick();
    total++;
    if (alu_res_q !== 32'h7FFF_FFFF || status_q !== 4'b0011) begin
      bad++; $display("FAIL sub_ovf res=%h status=%b want 7fffffff 0011", alu_res_q, status_q);
    end
  endtask

  task automatic test_adc_logic();
    issue(4'b0011, 1'b1, 32'hFFFF_FFFF, 32'd0);
    tick();
    total++;
    if (alu_res_q !== 32'd0 || status_q !== 4'b0110) begin
      bad++; $display("FAIL adc_c res=%h status=%b want 0 0110", alu_res_q, status_q);
    end
    issue(4'b0110, 1'b1, 32'h8000_00FF, 32'hF000_000F);
    tick();
    total++;
    if (alu_res_q !== 32'h8000_000F || status_q !== 4'b1010) begin
      bad++; $display("FAIL and_keepc res=%h status=%b want 8000000f 1010", alu_res_q, status_q);
    end
    issue(4'b0111, 1'b1, 32'h0000_00F0, 32'h0000_000F);
    tick();
    total++;
    if (alu_res_q !== 32'h0000_00FF || status_q !== 4'b0010) begin
      bad++; $display("FAIL orr res=%h status=%b want ff 0010", alu_res_q, status_q);
    end
    issue(4'b1000, 1'b0, 32'h0000_00FF, 32'h0000_000F);
    tick();
    total++;
    if (alu_res_q !== 32'h0000_00F0 || status_q !== 4'b0010) begin
      bad++; $display("FAIL eor res=%h status=%b want f0 0010", alu_res_q, status_q);
    end
    issue(4'b1001, 1'b1, 32'h0, 32'h0);
    tick();
    total++;
    if (alu_res_q !== 32'hFFFF_FFFF || status_q !== 4'b1010) begin
      bad++; $display("FAIL mvn res=%h status=%b want ffffffff 1010", alu_res_q, status_q);
    end
    issue(4'b1111, 1'b1, 32'h1234, 32'h5678);
    tick();
    total++;
    if (alu_res_q !== 32'd0 || status_q !== 4'b0110) begin
      bad++; $display("FAIL undef_op res=%h status=%b want 0 0110", alu_res_q, status_q);
    end
  endtask

  task automatic test_no_s_freeze();
    issue(4'b0010, 1'b0, 32'h7FFF_FFFF, 32'h1);
    dest_in = 4'd5;
    tick();
    total++;
    if (alu_res_q !== 32'h8000_0000 || status_q !== 4'b0110) begin
      bad++; $display("FAIL no_s res=%h status=%b want 80000000 0110", alu_res_q, status_q);
    end
    freeze = 1'b1;
    issue(4'b0001, 1'b1, 32'h0, 32'h1234);
    dest_in = 4'd7; valid_in = 1'b0; st_val_in = 32'h0;
    tick();
    total++;
    if (alu_res_q !== 32'h8000_0000 || status_q !== 4'b0110 || dest_q !== 4'd5 ||
        valid_q !== 1'b1 || st_val_q !== 32'hCAFE_0001) begin
      bad++; $display("FAIL freeze_hold res=%h status=%b dest=%0d valid=%b want 80000000 0110 5 1", alu_res_q, status_q, dest_q, valid_q);
    end
    freeze = 1'b0;
  endtask

  task automatic test_flush();
    flush = 1'b1;
    issue(4'b0001, 1'b1, 32'h0, 32'h55);
    tick();
    total++;
    if (valid_q !== 1'b0 || wb_en_q !== 1'b0 || alu_res_q !== 32'h8000_0000 || status_q !== 4'b0110) begin
      bad++; $display("FAIL flush valid=%b wb=%b res=%h status=%b want 0 0 80000000 0110", valid_q, wb_en_q, alu_res_q, status_q);
    end
    flush = 1'b0;
    issue(4'b0001, 1'b1, 32'h0, 32'hAA);
    tick();
    flush = 1'b1; freeze = 1'b1;
    issue(4'b0001, 1'b1, 32'h0, 32'h0);
    tick();
    total++;
    if (valid_q !== 1'b1 || wb_en_q !== 1'b1 || alu_res_q !== 32'hAA || status_q !== 4'b0010) begin
      bad++; $display("FAIL flush_freeze valid=%b wb=%b res=%h status=%b want 1 1 aa 0010", valid_q, wb_en_q, alu_res_q, status_q);
    end
    flush = 1'b0; freeze = 1'b0;
  endtask

  task automatic test_bubble();
    issue(4'b0001, 1'b1, 32'h0, 32'h77);
    valid_in = 1'b0; mem_w_en_in = 1'b1; mem_r_en_in = 1'b1;
    tick();
    total++;
    if (valid_q !== 1'b0 || wb_en_q !== 1'b0 || mem_w_en_q !== 1'b0 || mem_r_en_q !== 1'b0 ||
        alu_res_q !== 32'h77 || status_q !== 4'b0010) begin
      bad++; $display("FAIL bubble valid=%b wb=%b mw=%b res=%h status=%b want 0 0 0 77 0010", valid_q, wb_en_q, mem_w_en_q, alu_res_q, status_q);
    end
    issue(4'b0010, 1'b0, 32'h10, 32'h20);
    mem_r_en_in = 1'b1;
    tick();
    total++;
    if (valid_q !== 1'b1 || mem_r_en_q !== 1'b1 || alu_res_q !== 32'h30) begin
      bad++; $display("FAIL ldr_addr valid=%b mr=%b res=%h want 1 1 30", valid_q, mem_r_en_q, alu_res_q);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({alu_res_q, valid_q, wb_en_q, mem_r_en_q, status_q} !== '0) begin
      bad++; $display("FAIL async_rst res=%h valid=%b status=%b want 0 0 0", alu_res_q, valid_q, status_q);
    end
    #1 rst_n = 1'b1;
    issue(4'b0010, 1'b1, 32'd1, 32'd2);
    tick();
    total++;
    if (alu_res_q !== 32'd3 || valid_q !== 1'b1 || status_q !== 4'b0000) begin
      bad++; $display("FAIL post_rst res=%h valid=%b status=%b want 3 1 0000", alu_res_q, valid_q, status_q);
    end
  endtask

  task automatic test_branch();
    freeze = 1'b1; flush = 1'b1;
    pc_in = 32'h100; imm24 = 24'hFF_FFFE;
    #1;
    total++;
    if (branch_addr !== 32'hF8) begin
      bad++; $display("FAIL branch_neg got=%h want f8", branch_addr);
    end
    pc_in = 32'h1000; imm24 = 24'h00_0004;
    #1;
    total++;
    if (branch_addr !== 32'h1010) begin
      bad++; $display("FAIL branch_pos got=%h want 1010", branch_addr);
    end
    freeze = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    #1;
    test_add_overflow();
    test_sub_sbc();
    test_adc_logic();
    test_no_s_freeze();
    test_flush();
    test_bubble();
    test_async_reset();
    test_branch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
